// File: rtl/handshake_rr_ctrl_arbiter.sv
// Round-robin arbiter that shares one registered index channel between NUM_INPUTS control channels.
// Optional accepted-token counter enabled by defining HANDSHAKE_ARB_STATS_EN.
module handshake_rr_ctrl_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_INPUTS-1:0]         ins_valid,
    output logic [NUM_INPUTS-1:0]         ins_ready,
    output logic [INDEX_WIDTH-1:0]        index,
    output logic                          index_valid,
    input  logic                          index_ready,
    output logic [15:0]                   grant_count,
    output logic                          state_dbg,
    output logic [$clog2(NUM_INPUTS)-1:0] rr_ptr_dbg
);

    // Handshake: a token moves on a channel in any cycle where valid and ready are
    // both high at the rising edge; valid never waits on ready, and ready here is
    // derived from downstream space and the round-robin choice only.

    localparam int               PTR_W = $clog2(NUM_INPUTS);
    localparam logic [PTR_W:0]   N_EXT = (PTR_W + 1)'(NUM_INPUTS);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_INPUTS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [PTR_W-1:0]         rr_ptr_q;
    logic [INDEX_WIDTH-1:0]   index_q;
    logic [PTR_W-1:0]         winner;
    logic [PTR_W:0]           cand;
    logic                     found;
    logic                     can_accept;
    logic                     transfer;

    assign can_accept = (state_q == EMPTY) | index_ready;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int off = 0; off < NUM_INPUTS; off++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(off);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!found && ins_valid[cand[PTR_W-1:0]]) begin
                winner = cand[PTR_W-1:0];
                found  = 1'b1;
            end
        end
    end

    // ins_ready is gated by rst so it is all-zero the moment reset asserts.
    always_comb begin
        ins_ready = '0;
        if (rst && can_accept && found) begin
            ins_ready[winner] = 1'b1;
        end
    end

    assign transfer = |(ins_ready & ins_valid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (transfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (index_ready && !transfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_q  <= '0;
            rr_ptr_q <= '0;
        end else if (transfer) begin
            index_q  <= INDEX_WIDTH'(winner);
            rr_ptr_q <= (winner == LAST) ? '0 : winner + PTR_W'(1);
        end
    end

`ifdef HANDSHAKE_ARB_STATS_EN
    logic [15:0] grant_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_count_q <= 16'h0000;
        end else if (transfer) begin
            grant_count_q <= grant_count_q + 16'h0001;
        end
    end

    assign grant_count = grant_count_q;
`else
    assign grant_count = 16'h0000;
`endif

    assign index       = index_q;
    assign index_valid = (state_q == FULL);
    assign state_dbg   = state_q;
    assign rr_ptr_dbg  = rr_ptr_q;

endmodule

// File: tb/tb_handshake_rr_ctrl_arbiter.sv
// Directed bench for handshake_rr_ctrl_arbiter: expected indices are queued by the
// driver and popped by a monitor whenever the output channel hands over a token.
module tb_handshake_rr_ctrl_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] ins_valid;
    logic [N-1:0] ins_ready;
    logic [W-1:0] index;
    logic         index_valid;
    logic         index_ready;
    logic [15:0]  grant_count;
    logic         state_dbg;
    logic [1:0]   rr_ptr_dbg;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_fail;
    logic [15:0]  exp_cnt;

    handshake_rr_ctrl_arbiter #(
        .NUM_INPUTS (N),
        .INDEX_WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .index      (index),
        .index_valid(index_valid),
        .index_ready(index_ready),
        .grant_count(grant_count),
        .state_dbg  (state_dbg),
        .rr_ptr_dbg (rr_ptr_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r);
        ins_valid   = v;
        index_ready = r;
        #1;
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b0;
        ins_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [15:0] cnt_exp(input int n);
`ifdef HANDSHAKE_ARB_STATS_EN
        return 16'(n);
`else
        return 16'h0000 & 16'(n);
`endif
    endfunction

    // scoreboard monitor: a token leaves when index_valid & index_ready at the edge
    always @(negedge clk) begin
        if (rst && index_valid && index_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_token: got index %0d expected none (queue empty) at %0t", index, $time);
            end else begin
                check("out_token", 32'(index), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        ins_valid   = '0;
        index_ready = 1'b0;

        // 1: reset holds everything idle even with requests present
        #2;
        drive(4'b1111, 1'b1);
        check("rst_ins_ready", 32'(ins_ready), 32'h0);
        check("rst_index_valid", 32'(index_valid), 32'h0);
        check("rst_index", 32'(index), 32'h0);
        check("rst_grant_count", 32'(grant_count), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        repeat (2) step();

        // 2: single request on input 2
        rst = 1'b1;
        drive(4'b0100, 1'b1);
        check("t2_ins_ready", 32'(ins_ready), 32'b0100);
        exp_q.push_back(2'd2);
        step();
        drive(4'b0000, 1'b1);
        check("t2_index", 32'(index), 32'd2);
        check("t2_index_valid", 32'(index_valid), 32'd1);
        check("t2_rr_ptr", 32'(rr_ptr_dbg), 32'd3);
        step();
        check("t2_drained", 32'(index_valid), 32'd0);

        // 3: all requesting from reset, rotation 0,1,2,3,0
        do_reset();
        drive(4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("t3_ins_ready", 32'(ins_ready), 32'(1 << (k % 4)));
            exp_q.push_back(W'(k % 4));
            step();
            check("t3_index", 32'(index), 32'(k % 4));
        end
        drive(4'b0000, 1'b1);
        exp_cnt = cnt_exp(5);
        check("t3_grant_count", 32'(grant_count), 32'(exp_cnt));
        check("t3_rr_ptr", 32'(rr_ptr_dbg), 32'd1);
        step();

        // 4: backpressure holds the token and freezes arbitration
        drive(4'b1111, 1'b1);
        check("t4_ins_ready_a", 32'(ins_ready), 32'b0010);
        exp_q.push_back(2'd1);
        step();
        drive(4'b1111, 1'b0);
        check("t4_ins_ready_stall", 32'(ins_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_index_hold", 32'(index), 32'd1);
            check("t4_valid_hold", 32'(index_valid), 32'd1);
            check("t4_ready_hold", 32'(ins_ready), 32'h0);
        end
        drive(4'b1111, 1'b1);
        check("t4_ins_ready_b", 32'(ins_ready), 32'b0100);
        exp_q.push_back(2'd2);
        step();
        drive(4'b0000, 1'b1);
        check("t4_index_next", 32'(index), 32'd2);
        check("t4_rr_ptr", 32'(rr_ptr_dbg), 32'd3);
        step();

        // 5: wrap from pointer 3 with inputs 3 and 0
        drive(4'b1001, 1'b1);
        check("t5_ins_ready_a", 32'(ins_ready), 32'b1000);
        exp_q.push_back(2'd3);
        step();
        check("t5_ins_ready_b", 32'(ins_ready), 32'b0001);
        exp_q.push_back(2'd0);
        step();
        check("t5_ins_ready_c", 32'(ins_ready), 32'b1000);
        exp_q.push_back(2'd3);
        step();
        drive(4'b0000, 1'b1);
        check("t5_index", 32'(index), 32'd3);
        step();

        // 6: asynchronous reset discards a held token
        drive(4'b1000, 1'b1);
        check("t6_ins_ready", 32'(ins_ready), 32'b1000);
        step();
        drive(4'b0000, 1'b0);
        check("t6_index", 32'(index), 32'd3);
        check("t6_valid", 32'(index_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(index_valid), 32'd0);
        check("t6_async_index", 32'(index), 32'd0);
        check("t6_async_cnt", 32'(grant_count), 32'd0);
        step();
        rst = 1'b1;
        drive(4'b1111, 1'b1);
        check("t6_first_grant", 32'(ins_ready), 32'b0001);
        exp_q.push_back(2'd0);
        step();
        drive(4'b0000, 1'b1);
        check("t6_index_after", 32'(index), 32'd0);
        exp_cnt = cnt_exp(1);
        check("t6_grant_count", 32'(grant_count), 32'(exp_cnt));

        // drain with a bounded wait
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            step();
        end
        step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_state", 32'(state_dbg), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
